// File: rtl/fir_axil_ctrl.sv
// fir_axil_ctrl: AXI4-Lite control slave for the FIR engine (ap_ctrl, tap_num, data_num, tap BRAM arbitration); FIR_CTRL_IRQ_EN adds irq_en at 0x04 and out_irq
module fir_axil_ctrl #(
    parameter int pADDR_WIDTH      = 12,
    parameter int pDATA_WIDTH      = 32,
    parameter int pADDR_WIDTH_TAP  = 4,
    parameter int pADDR_WIDTH_DATA = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [pADDR_WIDTH-1:0]      awaddr,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [pDATA_WIDTH-1:0]      wdata,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [pADDR_WIDTH-1:0]      araddr,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [pDATA_WIDTH-1:0]      rdata,
    output logic [1:0]                  rresp,
    output logic                        out_ap_start,
    input  logic                        in_ap_done,
    output logic [pADDR_WIDTH_TAP-1:0]  out_tap_num,
    output logic [pADDR_WIDTH_DATA-1:0] out_data_num,
    input  logic [pADDR_WIDTH_TAP-1:0]  in_eng_A_tap,
    input  logic                        in_eng_EN_tap,
    output logic [pDATA_WIDTH-1:0]      out_eng_Do_tap,
    output logic [pADDR_WIDTH_TAP-1:0]  out_tap_A,
    output logic                        out_tap_EN,
    output logic [3:0]                  out_tap_WE,
    output logic [pDATA_WIDTH-1:0]      out_tap_Di,
`ifdef FIR_CTRL_IRQ_EN
    output logic                        out_irq,
`endif
    input  logic [pDATA_WIDTH-1:0]      in_tap_Do
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [2:0] {K_CTRL, K_IRQ, K_DNUM, K_TNUM, K_TAP, K_BAD} kind_t;
    localparam int AW = pADDR_WIDTH - 2;
    localparam logic [AW-1:0] W_IRQ  = AW'(1);
    localparam logic [AW-1:0] W_DNUM = AW'(4);
    localparam logic [AW-1:0] W_TNUM = AW'(5);
    localparam logic [AW-1:0] W_TAP0 = AW'(32);
    localparam logic [AW-1:0] W_TAP1 = AW'(32 + 2 ** pADDR_WIDTH_TAP);
`ifdef FIR_CTRL_IRQ_EN
    localparam logic IRQ_MAP = 1'b1;
`else
    localparam logic IRQ_MAP = 1'b0;
`endif

    function automatic kind_t dec(input logic [pADDR_WIDTH-1:0] a);
        logic [AW-1:0] w;
        w = a[pADDR_WIDTH-1:2];
        return a[1:0] != 2'd0 ? K_BAD :
               w == '0 ? K_CTRL :
               (w == W_IRQ && IRQ_MAP) ? K_IRQ :
               w == W_DNUM ? K_DNUM :
               w == W_TNUM ? K_TNUM :
               (w >= W_TAP0 && w < W_TAP1) ? K_TAP : K_BAD;
    endfunction

    function automatic logic [pADDR_WIDTH_TAP-1:0] tap_idx(input logic [pADDR_WIDTH-1:0] a);
        return pADDR_WIDTH_TAP'(a[pADDR_WIDTH-1:2] - W_TAP0);
    endfunction

    state_t state, state_nx;
    kind_t w_kind, r_kind;
    logic aw_rdy, ar_en, r_pend, r_wait, r_clr, ap_start_q, irq_en;
    logic wr_hs, ar_hs, w_err, r_err, wr_ok, start_wr, tap_wr, tap_rd;
    logic [pADDR_WIDTH_TAP-1:0] r_idx, tap_num;
    logic [pADDR_WIDTH_DATA-1:0] data_num;
    logic [pDATA_WIDTH-1:0] reg_val;

    assign awready = aw_rdy;
    assign wready = aw_rdy;
    assign arready = ar_en && !(rvalid || r_pend || r_wait);
    assign wr_hs = aw_rdy && awvalid && wvalid;
    assign ar_hs = arready && arvalid;
    assign w_kind = dec(awaddr);
    assign r_kind = dec(araddr);
    assign w_err = w_kind == K_BAD || (state == BUSY && w_kind inside {K_DNUM, K_TNUM, K_TAP});
    assign r_err = r_kind == K_BAD || (state == BUSY && r_kind inside {K_DNUM, K_TNUM, K_TAP});
    assign wr_ok = wr_hs && !w_err;
    assign start_wr = wr_ok && w_kind == K_CTRL && wdata[0] && state != BUSY;
    assign tap_wr = wr_ok && w_kind == K_TAP;
    assign tap_rd = ar_hs && !r_err && r_kind == K_TAP;
    assign reg_val = r_kind == K_CTRL ? pDATA_WIDTH'({state != BUSY, state == DONE, state == BUSY}) :
                     r_kind == K_IRQ  ? pDATA_WIDTH'(irq_en) :
                     r_kind == K_DNUM ? pDATA_WIDTH'(data_num) :
                     r_kind == K_TNUM ? pDATA_WIDTH'(tap_num) : '0;
    assign out_ap_start = ap_start_q;
    assign out_tap_num = tap_num;
    assign out_data_num = data_num;
    assign out_eng_Do_tap = in_tap_Do;

    // a tap read colliding with a host tap write is replayed from r_idx one cycle later
    always_comb begin
        state_nx = start_wr ? BUSY :
                   (state == BUSY && in_ap_done) ? DONE :
                   (state == DONE && rvalid && rready && r_clr) ? IDLE : state;
        out_tap_A = state == BUSY ? in_eng_A_tap : tap_wr ? tap_idx(awaddr) : r_pend ? r_idx : tap_idx(araddr);
        out_tap_EN = state == BUSY ? in_eng_EN_tap : (tap_wr || r_pend || tap_rd);
        out_tap_WE = tap_wr ? 4'hF : 4'h0;
        out_tap_Di = tap_wr ? wdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            aw_rdy <= 1'b0;
            ar_en <= 1'b0;
            ap_start_q <= 1'b0;
            bvalid <= 1'b0;
            bresp <= 2'b00;
            rvalid <= 1'b0;
            rresp <= 2'b00;
            rdata <= '0;
            data_num <= '0;
            tap_num <= '0;
            r_pend <= 1'b0;
            r_wait <= 1'b0;
            r_clr <= 1'b0;
            r_idx <= '0;
        end else begin
            state <= state_nx;
            ar_en <= 1'b1;
            aw_rdy <= awvalid && wvalid && !bvalid && !aw_rdy;
            ap_start_q <= start_wr;
            if (wr_hs) begin
                bvalid <= 1'b1;
                bresp <= w_err ? 2'b10 : 2'b00;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            if (wr_ok && w_kind == K_DNUM) data_num <= pADDR_WIDTH_DATA'(wdata);
            if (wr_ok && w_kind == K_TNUM) tap_num <= pADDR_WIDTH_TAP'(wdata);
            if (rvalid && rready) rvalid <= 1'b0;
            if (r_pend) begin
                r_pend <= 1'b0;
                r_wait <= 1'b1;
            end
            if (r_wait) begin
                r_wait <= 1'b0;
                rvalid <= 1'b1;
                rresp <= 2'b00;
                rdata <= in_tap_Do;
            end
            if (tap_rd) begin
                r_pend <= tap_wr;
                r_wait <= !tap_wr;
                r_idx <= tap_idx(araddr);
            end else if (ar_hs) begin
                rvalid <= 1'b1;
                rresp <= r_err ? 2'b10 : 2'b00;
                rdata <= r_err ? '0 : reg_val;
                r_clr <= r_kind == K_CTRL && state == DONE;
            end
            if (start_wr) r_clr <= 1'b0;
        end
    end

`ifdef FIR_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_en <= 1'b0;
        else if (wr_ok && w_kind == K_IRQ) irq_en <= wdata[0];
    end
    assign out_irq = irq_en && state == DONE;
`else
    assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_fir_axil_ctrl.sv
// tb_fir_axil_ctrl: directed bench for fir_axil_ctrl with a behavioural read-first tap BRAM
module tb_fir_axil_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [1:0] bresp, rresp;
    logic out_ap_start, in_ap_done, in_eng_EN_tap, out_tap_EN;
    logic [3:0] out_tap_num, in_eng_A_tap, out_tap_A, out_tap_WE;
    logic [9:0] out_data_num;
    logic [31:0] out_eng_Do_tap, out_tap_Di;
    logic [31:0] in_tap_Do = '0;
    logic out_irq;
    logic [31:0] mem [16];
    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic st_after;

    fir_axil_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .out_ap_start(out_ap_start), .in_ap_done(in_ap_done),
        .out_tap_num(out_tap_num), .out_data_num(out_data_num),
        .in_eng_A_tap(in_eng_A_tap), .in_eng_EN_tap(in_eng_EN_tap), .out_eng_Do_tap(out_eng_Do_tap),
        .out_tap_A(out_tap_A), .out_tap_EN(out_tap_EN), .out_tap_WE(out_tap_WE), .out_tap_Di(out_tap_Di),
`ifdef FIR_CTRL_IRQ_EN
        .out_irq(out_irq),
`endif
        .in_tap_Do(in_tap_Do)
    );

`ifndef FIR_CTRL_IRQ_EN
    assign out_irq = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_tap_EN) begin
            if (out_tap_WE == 4'hF) mem[out_tap_A] <= out_tap_Di;
            in_tap_Do <= mem[out_tap_A];
        end
    end

    always @(posedge clk) if (out_ap_start) start_cnt <= start_cnt + 1;

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; st_after = out_ap_start; n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        resp = bresp;
        checks++;
        if (!bvalid) begin failures++; $display("FAIL write_timeout addr=%h bvalid=0 want 1", a); end
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0; lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        d = rdata; resp = rresp;
        checks++;
        if (!rvalid) begin failures++; $display("FAIL read_timeout addr=%h rvalid=0 want 1", a); end
    endtask

    task automatic pulse_done();
        @(negedge clk); in_ap_done = 1'b1;
        @(negedge clk); in_ap_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, out_ap_start, out_tap_EN} !== 7'b0) begin
            failures++; $display("FAIL reset_handshake got=%b want 0", {awready, wready, arready, bvalid, rvalid, out_ap_start, out_tap_EN});
        end
        checks++;
        if (out_tap_num !== 4'd0 || out_data_num !== 10'd0) begin
            failures++; $display("FAIL reset_cfg tap_num=%0d data_num=%0d want 0 0", out_tap_num, out_data_num);
        end
        checks++;
        if (out_tap_WE !== 4'h0 || rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            failures++; $display("FAIL reset_regs we=%h rdata=%h bresp=%b rresp=%b want 0", out_tap_WE, rdata, bresp, rresp);
        end
        @(negedge clk); rst_n = 1'b1;
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h4 || r !== 2'b00 || lat !== 1) begin
            failures++; $display("FAIL reset_ctrl rdata=%h resp=%b lat=%0d want 4 00 1", d, r, lat);
        end
    endtask

    task automatic test_tap();
        logic [31:0] d; logic [1:0] r; int lat;
        for (int i = 0; i < 11; i++) begin
            axi_write(12'h080 + 12'(4 * i), 32'(i + 1), r);
            checks++;
            if (r !== 2'b00) begin failures++; $display("FAIL tap_wr_resp idx=%0d resp=%b want 00", i, r); end
        end
        checks++;
        if (mem[5] !== 32'd6) begin failures++; $display("FAIL tap_bram_content mem5=%0d want 6", mem[5]); end
        axi_read(12'h094, d, r, lat);
        checks++;
        if (d !== 32'd6 || r !== 2'b00 || lat !== 2) begin
            failures++; $display("FAIL tap_rd rdata=%0d resp=%b lat=%0d want 6 00 2", d, r, lat);
        end
        axi_read(12'h200, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL unmapped_rd rdata=%h resp=%b want 0 10", d, r); end
        axi_read(12'h0C0, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL tap16_rd rdata=%h resp=%b want 0 10", d, r); end
        axi_write(12'h0C0, 32'h77, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL tap16_wr resp=%b want 10", r); end
    endtask

    task automatic test_conflict();
        int lat;
        @(negedge clk);
        awaddr = 12'h0B0; wdata = 32'hABCD; awvalid = 1'b1; wvalid = 1'b1; lat = 0;
        while (!awready && lat < 20) begin @(negedge clk); lat++; end
        araddr = 12'h0B0; arvalid = 1'b1;
        #1;
        checks++;
        if (!arready || out_tap_WE !== 4'hF || out_tap_A !== 4'd12 || out_tap_EN !== 1'b1) begin
            failures++; $display("FAIL conflict_wr arready=%b we=%h a=%0d en=%b want 1 f 12 1", arready, out_tap_WE, out_tap_A, out_tap_EN);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; lat = 1;
        checks++;
        if (out_tap_EN !== 1'b1 || out_tap_WE !== 4'h0 || out_tap_A !== 4'd12) begin
            failures++; $display("FAIL conflict_replay en=%b we=%h a=%0d want 1 0 12", out_tap_EN, out_tap_WE, out_tap_A);
        end
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (rdata !== 32'hABCD || rresp !== 2'b00 || lat !== 3) begin
            failures++; $display("FAIL conflict_rd rdata=%h resp=%b lat=%0d want abcd 00 3", rdata, rresp, lat);
        end
    endtask

    task automatic test_config_run();
        logic [31:0] d; logic [1:0] r; int lat, s0;
        axi_write(12'h014, 32'h3B, r);
        axi_write(12'h010, 32'h1258, r);
        checks++;
        if (out_tap_num !== 4'd11 || out_data_num !== 10'd600) begin
            failures++; $display("FAIL cfg_out tap_num=%0d data_num=%0d want 11 600", out_tap_num, out_data_num);
        end
        axi_read(12'h010, d, r, lat);
        checks++;
        if (d !== 32'h258 || r !== 2'b00) begin failures++; $display("FAIL cfg_rd data_num=%h resp=%b want 258 00", d, r); end
        s0 = start_cnt;
        axi_write(12'h000, 32'h1, r);
        checks++;
        if (st_after !== 1'b1 || r !== 2'b00) begin failures++; $display("FAIL start_timing ap_start=%b resp=%b want 1 00", st_after, r); end
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 1) begin failures++; $display("FAIL start_pulse cycles=%0d want 1", start_cnt - s0); end
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin failures++; $display("FAIL busy_ctrl rdata=%h resp=%b want 1 00", d, r); end
        axi_write(12'h080, 32'h55, r);
        checks++;
        if (r !== 2'b10 || mem[0] !== 32'd1) begin failures++; $display("FAIL busy_tap_wr resp=%b mem0=%0d want 10 1", r, mem[0]); end
        axi_read(12'h080, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL busy_tap_rd rdata=%h resp=%b want 0 10", d, r); end
        axi_write(12'h010, 32'h5, r);
        checks++;
        if (r !== 2'b10 || out_data_num !== 10'd600) begin failures++; $display("FAIL busy_cfg_wr resp=%b data_num=%0d want 10 600", r, out_data_num); end
        axi_read(12'h014, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL busy_cfg_rd rdata=%h resp=%b want 0 10", d, r); end
    endtask

    task automatic test_engine();
        @(negedge clk);
        in_eng_A_tap = 4'd3; in_eng_EN_tap = 1'b1;
        #1;
        checks++;
        if (out_tap_A !== 4'd3 || out_tap_EN !== 1'b1 || out_tap_WE !== 4'h0) begin
            failures++; $display("FAIL eng_mux a=%0d en=%b we=%h want 3 1 0", out_tap_A, out_tap_EN, out_tap_WE);
        end
        @(negedge clk);
        checks++;
        if (out_eng_Do_tap !== 32'd4) begin failures++; $display("FAIL eng_do do=%0d want 4", out_eng_Do_tap); end
        in_eng_EN_tap = 1'b0; in_eng_A_tap = 4'd0;
    endtask

    task automatic test_done();
        logic [31:0] d; logic [1:0] r; int lat, s0;
        s0 = start_cnt;
        pulse_done();
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL done_rd1 rdata=%h want 6", d); end
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL done_rd2 rdata=%h want 4", d); end
        checks++;
        if (start_cnt !== s0) begin failures++; $display("FAIL done_no_restart pulses=%0d want 0", start_cnt - s0); end
        pulse_done();
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL idle_done_ignored rdata=%h want 4", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; int lat, s0;
        s0 = start_cnt;
        axi_write(12'h000, 32'h1, r);
        pulse_done();
        axi_write(12'h000, 32'h1, r);
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h1 || start_cnt - s0 !== 2) begin
            failures++; $display("FAIL done_restart rdata=%h pulses=%0d want 1 2", d, start_cnt - s0);
        end
        @(negedge clk);
        checks++;
        if (!arready) begin failures++; $display("FAIL race_arready arready=0 want 1"); end
        araddr = 12'h000; arvalid = 1'b1; in_ap_done = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; in_ap_done = 1'b0; lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (rdata !== 32'h1) begin failures++; $display("FAIL race_rd rdata=%h want 1", rdata); end
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL race_done rdata=%h want 6", d); end
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL race_clear rdata=%h want 4", d); end
    endtask

`ifdef FIR_CTRL_IRQ_EN
    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_write(12'h004, 32'h1, r);
        axi_read(12'h004, d, r, lat);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin failures++; $display("FAIL irq_en_rd rdata=%h resp=%b want 1 00", d, r); end
        axi_write(12'h000, 32'h1, r);
        pulse_done();
        checks++;
        if (out_irq !== 1'b1) begin failures++; $display("FAIL irq_set out_irq=%b want 1", out_irq); end
        axi_read(12'h000, d, r, lat);
        @(negedge clk);
        checks++;
        if (d !== 32'h6 || out_irq !== 1'b0) begin failures++; $display("FAIL irq_clear rdata=%h out_irq=%b want 6 0", d, out_irq); end
        axi_write(12'h000, 32'h1, r);
        axi_read(12'h004, d, r, lat);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin failures++; $display("FAIL irq_busy_rd rdata=%h resp=%b want 1 00", d, r); end
    endtask
`else
    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_read(12'h004, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL irq_unmapped_rd rdata=%h resp=%b want 0 10", d, r); end
        axi_write(12'h004, 32'h1, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL irq_unmapped_wr resp=%b want 10", r); end
        axi_write(12'h000, 32'h1, r);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat;
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL mid_busy rdata=%h want 1", d); end
        @(negedge clk); in_eng_EN_tap = 1'b1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_tap_EN !== 1'b0 || out_tap_WE !== 4'h0 || out_irq !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL mid_reset en=%b we=%h irq=%b bvalid=%b rvalid=%b want 0", out_tap_EN, out_tap_WE, out_irq, bvalid, rvalid);
        end
        checks++;
        if (out_tap_num !== 4'd0 || out_data_num !== 10'd0) begin
            failures++; $display("FAIL mid_reset_cfg tap_num=%0d data_num=%0d want 0 0", out_tap_num, out_data_num);
        end
        in_eng_EN_tap = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        axi_read(12'h000, d, r, lat);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL mid_reset_idle rdata=%h want 4", d); end
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0;
        bready = 1'b1; rready = 1'b1;
        in_ap_done = 1'b0; in_eng_A_tap = '0; in_eng_EN_tap = 1'b0;
        test_reset();
        test_tap();
        test_conflict();
        test_config_run();
        test_engine();
        test_done();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
